// File: rtl/matrix_scan_scheduler.sv
// HUB75 refresh sequencer: walks row pairs and BCM bit planes, generating shift, latch and
// output-enable timing, and swaps the displayed framebuffer half at frame boundaries.
module matrix_scan_scheduler #(
  parameter int PIXEL_COLUMNS      = 64,
  parameter int ROW_BITS           = 4,
  parameter int PWM_BITS           = 4,
  parameter int BASE_DISPLAY_TICKS = 8,
  parameter int LATCH_CYCLES       = 2,
  localparam int COL_W             = $clog2(PIXEL_COLUMNS),
  localparam int BP_W              = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_swap_req,
  output logic                frame_swap_ack,
  output logic                frame_select,
  output logic [COL_W-1:0]    column_address,
  output logic [ROW_BITS-1:0] row_address,
  output logic [BP_W-1:0]     bitplane,
  output logic                pixel_clk,
  output logic                row_latch,
  output logic                oe_n,
  output logic [ROW_BITS-1:0] row_address_active
);

  localparam int DISP_W = $clog2(BASE_DISPLAY_TICKS << (PWM_BITS - 1)) + 1;
  localparam int LAT_W  = $clog2(LATCH_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t             state, state_next;
  logic [LAT_W-1:0]   lat_cnt;
  logic [DISP_W-1:0]  disp_cnt;
  logic [DISP_W-1:0]  plane_ticks;
  logic               pending;
  logic               last_col, lat_done, disp_done;
  logic               last_plane, last_row;
  logic               plane_end, frame_end, swap_now;

  // pixel_clk doubles as the shift phase bit: low = present column, high = clock it in
  assign plane_ticks = DISP_W'(BASE_DISPLAY_TICKS) << bitplane;
  assign last_col    = pixel_clk && (column_address == COL_W'(PIXEL_COLUMNS - 1));
  assign lat_done    = (lat_cnt == LAT_W'(LATCH_CYCLES - 1));
  assign disp_done   = (disp_cnt == plane_ticks - DISP_W'(1));
  assign last_plane  = (bitplane == BP_W'(PWM_BITS - 1));
  assign last_row    = &row_address;
  assign plane_end   = (state == DISPLAY) && disp_done;
  assign frame_end   = plane_end && last_plane && last_row;
  // a request landing in the boundary cycle itself still makes this frame's swap
  assign swap_now    = frame_end && (pending || frame_swap_req);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SHIFT;
      SHIFT:   if (last_col) state_next = BLANK;
      BLANK:   state_next = LATCH;
      LATCH:   if (lat_done) state_next = DISPLAY;
      DISPLAY: if (disp_done) state_next = enable ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      column_address     <= '0;
      row_address        <= '0;
      bitplane           <= '0;
      row_address_active <= '0;
      lat_cnt            <= '0;
      disp_cnt           <= '0;
      pending            <= 1'b0;
      frame_select       <= 1'b0;
      frame_swap_ack     <= 1'b0;
      pixel_clk          <= 1'b0;
      row_latch          <= 1'b0;
      oe_n               <= 1'b1;
    end else begin
      // panel strobes are decoded from the next state so they line up with it
      oe_n      <= (state_next != DISPLAY);
      row_latch <= (state_next == LATCH);
      pixel_clk <= (state == SHIFT) ? ~pixel_clk : 1'b0;

      if (state == SHIFT && pixel_clk)
        column_address <= last_col ? '0 : column_address + COL_W'(1);

      lat_cnt  <= (state == LATCH)   ? lat_cnt + LAT_W'(1)   : '0;
      disp_cnt <= (state == DISPLAY) ? disp_cnt + DISP_W'(1) : '0;

      if (state == BLANK)
        row_address_active <= row_address;

      if (plane_end) begin
        bitplane <= last_plane ? '0 : bitplane + BP_W'(1);
        if (last_plane)
          row_address <= row_address + ROW_BITS'(1);
      end

      frame_swap_ack <= swap_now;
      if (swap_now) begin
        frame_select <= ~frame_select;
        pending      <= 1'b0;
      end else if (frame_swap_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Scoreboard bench for matrix_scan_scheduler: per-plane and per-swap expectations are queued
// by the stimulus and consumed by a monitor as the DUT completes each plane or acks a swap.
module tb_matrix_scan_scheduler;
  localparam int COLS = 64, RB = 4, PB = 4, BASE = 8, LAT = 2;
  localparam int FRAME_CYCLES = 10304;

  logic       clk_in = 1'b0, reset = 1'b1, enable = 1'b0, frame_swap_req = 1'b0;
  logic       frame_swap_ack, frame_select, pixel_clk, row_latch, oe_n;
  logic [5:0] column_address;
  logic [3:0] row_address, row_address_active;
  logic [1:0] bitplane;

  matrix_scan_scheduler #(
    .PIXEL_COLUMNS(COLS), .ROW_BITS(RB), .PWM_BITS(PB),
    .BASE_DISPLAY_TICKS(BASE), .LATCH_CYCLES(LAT)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .frame_swap_req(frame_swap_req),
    .frame_swap_ack(frame_swap_ack), .frame_select(frame_select),
    .column_address(column_address), .row_address(row_address), .bitplane(bitplane),
    .pixel_clk(pixel_clk), .row_latch(row_latch), .oe_n(oe_n),
    .row_address_active(row_address_active)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0, checks = 0, viol = 0;

  task automatic chk(input string name, input longint act, input longint req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req_v);
    end
  endtask

  typedef struct {int rises; int lat; int row; int bp; int oe; int period;} plane_t;
  plane_t plane_q[$];
  int     ack_q[$];
  int     OE_TAB[4]  = '{8, 16, 32, 64};
  int     PER_TAB[4] = '{139, 147, 163, 195};

  function automatic plane_t mk(int r, int b, int per);
    plane_t p;
    p.rises = 64; p.lat = 2; p.row = r; p.bp = b; p.oe = OE_TAB[b]; p.period = per;
    return p;
  endfunction

  task automatic push_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int b = 0; b < 4; b++) plane_q.push_back(mk(r, b, PER_TAB[b]));
  endtask

  // monitor
  logic   p_pclk = 1'b0, p_lat = 1'b0, p_oe = 1'b1;
  int     rises = 0, lat_len = 0, oe_len = 0, lat_rises = 0, lat_row = 0;
  int     st_row = 0, st_bp = 0, pend_per = 0, last_start = 0, frame_start = -1, col_bad = 0;
  plane_t e;
  int     a;

  always @(negedge clk_in) begin
    if (reset) begin
      p_pclk = 1'b0; p_lat = 1'b0; p_oe = 1'b1;
      rises = 0; lat_len = 0; oe_len = 0; pend_per = 0; frame_start = -1; col_bad = 0;
    end else begin
      if (!oe_n && (row_latch || pixel_clk)) viol++;
      if (pixel_clk && !p_pclk) begin
        if (rises == 0) begin
          if (pend_per != 0) chk("plane_period", cyc - last_start, pend_per);
          if (row_address == 0 && bitplane == 0) begin
            if (frame_start >= 0) chk("frame_period", cyc - frame_start, FRAME_CYCLES);
            frame_start = cyc;
          end
          last_start = cyc; pend_per = 0;
          st_row = int'(row_address); st_bp = int'(bitplane);
        end
        if (int'(column_address) != rises) col_bad++;
        rises++;
      end
      if (row_latch && !p_lat) begin
        lat_rises = rises; lat_row = int'(row_address_active); lat_len = 0;
      end
      if (row_latch) lat_len++;
      if (!oe_n) oe_len++;
      if (oe_n && !p_oe) begin
        if (plane_q.size() == 0) chk("unexpected_plane", 1, 0);
        else begin
          e = plane_q.pop_front();
          chk("shift_rises", lat_rises, e.rises);
          chk("latch_len", lat_len, e.lat);
          chk("row_active", lat_row, e.row);
          chk("shift_row", st_row, e.row);
          chk("shift_plane", st_bp, e.bp);
          chk("oe_low_len", oe_len, e.oe);
          chk("column_seq_errors", col_bad, 0);
          pend_per = e.period;
        end
        rises = 0; oe_len = 0; col_bad = 0;
      end
      if (frame_swap_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_frame_select", frame_select, a);
          chk("ack_at_frame_start", {row_address, bitplane, column_address, pixel_clk}, 0);
        end
      end
      p_pclk = pixel_clk; p_lat = row_latch; p_oe = oe_n;
    end
  end

  task automatic pulse_req();
    frame_swap_req = 1'b1;
    @(negedge clk_in);
    frame_swap_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe_n"}, oe_n, 1);
    chk({tag, "_pixel_clk"}, pixel_clk, 0);
    chk({tag, "_row_latch"}, row_latch, 0);
    chk({tag, "_frame_select"}, frame_select, 0);
    chk({tag, "_ack"}, frame_swap_ack, 0);
    chk({tag, "_row_active"}, row_address_active, 0);
    chk({tag, "_row_bp_col"}, {row_address, bitplane, column_address}, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    chk_reset_outputs("reset0");

    push_rows(0, 15); push_rows(0, 15); push_rows(0, 15);
    plane_q.push_back(mk(0, 0, 139));
    plane_q.push_back(mk(0, 1, 147));
    plane_q.push_back(mk(0, 2, 0));
    plane_q.push_back(mk(0, 3, 195));
    ack_q.push_back(1); ack_q.push_back(0); ack_q.push_back(1);

    reset = 1'b0;
    @(negedge clk_in);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk_in); n++; end while (!pixel_clk && n < 10);
    chk("first_rise_delay", n, 2);

    // three requests in the middle of frame 1 collapse into one swap
    repeat (3000) @(negedge clk_in); pulse_req();
    repeat (1500) @(negedge clk_in); pulse_req();
    repeat (1500) @(negedge clk_in); pulse_req();
    for (n = 0; n < 12000 && !frame_select; n++) @(negedge clk_in);
    chk("swap1_reached", frame_select, 1);

    // request in the boundary cycle of frame 2 plus one cycle after it
    for (n = 0; n < 12000 && !(row_address == 15 && bitplane == 3 && !oe_n); n++)
      @(negedge clk_in);
    chk("f2_last_plane_reached", (row_address == 15 && bitplane == 3 && !oe_n), 1);
    repeat (63) @(negedge clk_in);
    frame_swap_req = 1'b1;
    @(negedge clk_in);
    chk("boundary_req_swapped", frame_select, 0);
    @(negedge clk_in);
    frame_swap_req = 1'b0;
    for (n = 0; n < 12000 && !frame_select; n++) @(negedge clk_in);
    chk("late_req_swapped_next_frame", frame_select, 1);

    // drop enable in the middle of plane 2's display
    for (n = 0; n < 2000 && !(row_address == 0 && bitplane == 2 && !oe_n); n++)
      @(negedge clk_in);
    chk("plane2_display_reached", (row_address == 0 && bitplane == 2 && !oe_n), 1);
    enable = 1'b0;
    repeat (45) @(negedge clk_in);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_pixel_clk", pixel_clk, 0);
    chk("idle_bitplane", bitplane, 3);
    chk("idle_row", row_address, 0);
    enable = 1'b1;

    // reset in the middle of SHIFT
    for (n = 0; n < 1000 && !(row_address == 1 && pixel_clk); n++) @(negedge clk_in);
    chk("row1_shift_reached", (row_address == 1 && pixel_clk), 1);
    repeat (21) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    chk_reset_outputs("reset_shift");

    // restart, set a pending swap, then reset during DISPLAY
    push_rows(0, 2);
    reset = 1'b0;
    repeat (100) @(negedge clk_in);
    pulse_req();
    for (n = 0; n < 3000 && !(row_address == 3 && !oe_n); n++) @(negedge clk_in);
    chk("row3_display_reached", (row_address == 3 && !oe_n), 1);
    chk("row3_active_before_reset", row_address_active, 3);
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    chk_reset_outputs("reset_display");

    // a full frame after reset: the discarded request must not swap
    push_rows(0, 15);
    plane_q.push_back(mk(0, 0, 0));
    reset = 1'b0;
    for (n = 0; n < 11000 && plane_q.size() > 1; n++) @(negedge clk_in);
    chk("frame5_planes_consumed", plane_q.size(), 1);
    repeat (10) @(negedge clk_in);
    chk("no_swap_after_reset", frame_select, 0);
    enable = 1'b0;
    for (n = 0; n < 300 && plane_q.size() > 0; n++) @(negedge clk_in);
    repeat (10) @(negedge clk_in);

    chk("oe_overlap_violations", viol, 0);
    chk("ack_queue_left", ack_q.size(), 0);
    chk("plane_queue_left", plane_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_scan_scheduler.md
# matrix_scan_scheduler

Sequences HUB75 panel refresh: walks row pairs and binary-coded-modulation bit planes, drives column addressing, the pixel shift clock, the row latch and the active-low output enable, and owns the double-buffer `frame_select` toggle. Sits between the framebuffer read port and the panel pins inside `main`. The command controller requests swaps only through `frame_swap_req`.

## Interface
Parameters:
- `PIXEL_COLUMNS`, 64: columns shifted per row pair.
- `ROW_BITS`, 4: row-address width; number of row pairs is 2**ROW_BITS.
- `PWM_BITS`, 4: number of bit planes per row.
- `BASE_DISPLAY_TICKS`, 8: lit time of plane 0; plane b is lit for BASE_DISPLAY_TICKS << b cycles.
- `LATCH_CYCLES`, 2: row_latch high duration.

Ports:
- `clk_in`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run the scan; sampled as described under Operation.
- `frame_swap_req`  in  1  one-cycle pulse; requests a buffer swap at the next frame boundary.
- `frame_swap_ack`  out  1  one-cycle pulse in the cycle `frame_select` toggles.
- `frame_select`  out  1  framebuffer half being displayed.
- `column_address`  out  $clog2(PIXEL_COLUMNS)  framebuffer read column.
- `row_address`  out  ROW_BITS  framebuffer read row (row being shifted).
- `bitplane`  out  $clog2(PWM_BITS) (min 1)  plane being shifted.
- `pixel_clk`  out  1  panel shift clock.
- `row_latch`  out  1  panel latch.
- `oe_n`  out  1  panel output enable, active low.
- `row_address_active`  out  ROW_BITS  row address presented to the panel (ROA pins).

## Operation
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: `oe_n`=1, `pixel_clk`=0, `row_latch`=0. Goes to SHIFT on the cycle after `enable` is sampled high.
- SHIFT: two cycles per column c = 0..PIXEL_COLUMNS-1.
  - Phase 0: `column_address`=c, `pixel_clk`=0.
  - Phase 1: `pixel_clk`=1.
  - The framebuffer's 1-cycle read latency therefore presents data before the rising edge.
  - After the last phase 1, go to BLANK.
- BLANK: one cycle, `oe_n`=1.
- LATCH: `row_latch`=1 for LATCH_CYCLES cycles. `row_address_active` loads `row_address` on the first LATCH cycle.
- DISPLAY: `oe_n`=0 for BASE_DISPLAY_TICKS << `bitplane` cycles. On exit:
  - Increment `bitplane`.
  - On wrap from PWM_BITS-1 to 0, increment `row_address`.
  - On wrap from 2**ROW_BITS-1 to 0, the frame boundary has been reached.
  - Then go to SHIFT if `enable` is high, else IDLE.
- `oe_n` is 1 in every state except DISPLAY. `oe_n` is never 0 in the same cycle as `row_latch`=1 or `pixel_clk`=1.
- Swap: `frame_swap_req` sets a sticky pending flag. Repeated requests while pending collapse into a single swap.
  - At a frame boundary with pending set (including a req arriving in that same boundary cycle), toggle `frame_select`, pulse `frame_swap_ack`, and clear pending.
  - A req that arrives after the boundary cycle waits for the next frame.
- `enable` falling mid-plane does not truncate it. The current plane completes through DISPLAY, then the block enters IDLE with counters retained. Re-enable resumes at the next plane.
- Reset, from any state, takes effect on the next edge: state IDLE; all counters, `row_address_active`, `frame_select`, and pending cleared to 0; `oe_n`=1; `pixel_clk`=0; `row_latch`=0; `frame_swap_ack`=0.

## Timing
- Plane duration, SHIFT entry to next SHIFT entry: 2*PIXEL_COLUMNS + 1 + LATCH_CYCLES + (BASE_DISPLAY_TICKS << b) cycles.
- With the default parameters:
  - Plane 0 takes 139 cycles.
  - Plane 3 takes 195 cycles.
  - One row takes 4*131 + 120 = 644 cycles.
  - One frame takes 10304 cycles.
- Outputs are registered: each output value appears in the cycle its state is current, with no combinational paths from inputs to outputs.
- `frame_swap_ack` is coincident with the first cycle `frame_select` holds its new value, which is the first SHIFT cycle of row 0 plane 0.
- `row_address` and `bitplane` change on the DISPLAY exit edge, so they are stable for the entire following SHIFT.

## Test plan
- Reset, then `enable`=1: the first `pixel_clk` rise is 2 cycles after SHIFT entry, and exactly 64 rises occur before `row_latch` goes high. `row_latch` is high for 2 cycles, then `oe_n`=0 for 8 cycles. Total plane-0 period is 139 cycles.
- Free-run one full frame: `row_address_active` steps 0..15 in order, `oe_n` low lengths repeat 8/16/32/64 per row, and the frame is 10304 cycles.
- Pulse `frame_swap_req` three times mid-frame: exactly one `frame_swap_ack` at the frame boundary, with `frame_select` going 0→1. A req asserted in the boundary cycle itself also swaps at that boundary.
- Deassert `enable` during DISPLAY of plane 2: `oe_n` stays low for the full 32 cycles, then IDLE with `oe_n`=1. Re-enable: the next shift is plane 3 of the same row.
- Assert `reset` mid-SHIFT and mid-DISPLAY: the next cycle has `oe_n`=1, `pixel_clk`=0, `row_latch`=0, `row_address_active`=0, `frame_select`=0, and the pending swap is discarded.
- Throughout all runs, check continuously: never `oe_n`=0 together with `row_latch`=1 or `pixel_clk`=1.
